// File: rtl/scandoubler_31k.sv
// scandoubler_31k
//   Line doubler for a 15 kHz, 6-bit RGB video source. Each input line is
//   written into one half of a ping-pong line buffer. The previously
//   completed line is read from the other half twice, at the pclk rate,
//   which gives 31 kHz VGA-compatible timing. hs is regenerated and vs is
//   re-timed so that it only changes at output line starts.
//
//   Optional feature macro: SCANLINES_EN. When it is defined, a scanlines
//   input is added. With scanlines=1, the second replay of each line is
//   output at half intensity.
//
// Parameters
//   MAX_W     line buffer depth in pixels (power of 2)
//   HS_WIDTH  output hsync pulse width in pclk cycles
//
// Ports
//   pclk       output pixel clock, twice the input pixel rate
//   reset      asynchronous, active-high
//   ce_pix     input pixel strobe
//   hs_in      input hsync, active high (sampled on ce_pix)
//   vs_in      input vsync, active high (sampled on ce_pix)
//   r_in/g_in/b_in   6-bit input colour
//   scanlines  half-intensity enable for the second replay (SCANLINES_EN only)
//   hs_out     regenerated hsync, active high
//   vs_out     line-aligned vsync, active high
//   r_out/g_out/b_out  6-bit output colour
module scandoubler_31k #(
    parameter int MAX_W    = 1024,
    parameter int HS_WIDTH = 48
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic       ce_pix,
    input  logic       hs_in,
    input  logic       vs_in,
    input  logic [5:0] r_in,
    input  logic [5:0] g_in,
    input  logic [5:0] b_in,
`ifdef SCANLINES_EN
    input  logic       scanlines,
`endif
    output logic       hs_out,
    output logic       vs_out,
    output logic [5:0] r_out,
    output logic [5:0] g_out,
    output logic [5:0] b_out
);

    localparam int AW = $clog2(MAX_W);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] ONE  = CW'(1);
    localparam logic [CW-1:0] LAST = CW'(MAX_W - 1);
    localparam logic [CW-1:0] FULL = CW'(MAX_W);

    logic [CW-1:0] wr_x, rd_x, line_len;
    logic          wr_buf, sub, hs_prev, vs_samp;
    logic          line_start;

    // The ce_pix that carries the hs_in rising edge is the last pixel of
    // the line it closes, so it is counted into line_len.
    assign line_start = ce_pix & hs_in & ~hs_prev;

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            wr_x     <= '0;
            line_len <= '0;
            wr_buf   <= 1'b0;
            hs_prev  <= 1'b0;
            vs_samp  <= 1'b0;
        end else if (ce_pix) begin
            hs_prev <= hs_in;
            vs_samp <= vs_in;
            if (line_start) begin
                // wr_x == LAST means the last address was written, either
                // exactly once or repeatedly after saturation.
                line_len <= (wr_x == LAST) ? FULL : wr_x + ONE;
                wr_x     <= '0;
                wr_buf   <= ~wr_buf;
            end else if (wr_x != LAST) begin
                wr_x <= wr_x + ONE;
            end
        end
    end

    // Both banks live in one array; the bank select is the address MSB.
    logic [17:0] mem [0:2*MAX_W-1];
    logic [AW:0] wr_addr, rd_addr;
    logic [17:0] ram_q;

    assign wr_addr = {wr_buf,  wr_x[AW-1:0]};
    assign rd_addr = {~wr_buf, rd_x[AW-1:0]};

    always_ff @(posedge pclk) begin
        if (ce_pix) mem[wr_addr] <= {r_in, g_in, b_in};
    end

    always_ff @(posedge pclk) begin
        ram_q <= mem[rd_addr];
    end

    // ------------------------------------------------------------------
    // Read side: two passes over the stored line, then hold at the end
    // until the next input line start.
    // ------------------------------------------------------------------
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            rd_x <= '0;
            sub  <= 1'b0;
        end else if (line_start) begin
            rd_x <= '0;
            sub  <= 1'b0;
        end else if (line_len == '0) begin
            // No complete line yet; park the counter instead of letting
            // it run past the buffer.
            rd_x <= '0;
        end else if (rd_x == line_len - ONE) begin
            if (!sub) begin
                rd_x <= '0;
                sub  <= 1'b1;
            end
        end else begin
            rd_x <= rd_x + ONE;
        end
    end

    // Stage 1: aligned with the RAM output register.
    logic blank1, hs1, vs1;

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            blank1 <= 1'b1;
            hs1    <= 1'b0;
            vs1    <= 1'b0;
        end else begin
            blank1 <= (line_len == '0);
            hs1    <= (32'(rd_x) < HS_WIDTH);
            if (rd_x == '0) vs1 <= vs_samp;
        end
    end

    logic half;
`ifdef SCANLINES_EN
    logic sub1;

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) sub1 <= 1'b0;
        else       sub1 <= sub;
    end

    assign half = scanlines & sub1;
`else
    assign half = 1'b0;
`endif

    // Stage 2: output registers.
    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            hs_out <= 1'b0;
            vs_out <= 1'b0;
            r_out  <= '0;
            g_out  <= '0;
            b_out  <= '0;
        end else begin
            hs_out <= hs1 & ~blank1;
            vs_out <= vs1;
            if (blank1) begin
                r_out <= '0;
                g_out <= '0;
                b_out <= '0;
            end else if (half) begin
                r_out <= {1'b0, ram_q[17:13]};
                g_out <= {1'b0, ram_q[11:7]};
                b_out <= {1'b0, ram_q[5:1]};
            end else begin
                r_out <= ram_q[17:12];
                g_out <= ram_q[11:6];
                b_out <= ram_q[5:0];
            end
        end
    end

endmodule

// File: tb/tb_scandoubler_31k.sv
// tb_scandoubler_31k
//   Self-checking bench for scandoubler_31k. A line-level reference model
//   (queues of stored pixels plus a replay position derived from the
//   number of pclk cycles since the last input line start) predicts every
//   output cycle. Table rows cover the line-length cases; hand-written
//   sequences cover startup, async reset and vsync.
module tb_scandoubler_31k;

    localparam int MAX_W = 1024;
    localparam int HSW   = 48;
`ifdef SCANLINES_EN
    localparam bit SL = 1'b1;
`else
    localparam bit SL = 1'b0;
`endif

    logic       pclk = 1'b0;
    logic       reset, ce_pix, hs_in, vs_in, scanlines;
    logic [5:0] r_in, g_in, b_in;
    logic       hs_out, vs_out;
    logic [5:0] r_out, g_out, b_out;

    always #5 pclk = ~pclk;

    scandoubler_31k #(.MAX_W(MAX_W), .HS_WIDTH(HSW)) dut (
        .pclk      (pclk),
        .reset     (reset),
        .ce_pix    (ce_pix),
        .hs_in     (hs_in),
        .vs_in     (vs_in),
        .r_in      (r_in),
        .g_in      (g_in),
        .b_in      (b_in),
`ifdef SCANLINES_EN
        .scanlines (scanlines),
`endif
        .hs_out    (hs_out),
        .vs_out    (vs_out),
        .r_out     (r_out),
        .g_out     (g_out),
        .b_out     (b_out)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d, required %0d", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        blank, hs, sub, vs, lv;
        logic [17:0] pix;
    } ent_t;

    localparam ent_t RST_ENT = '{blank: 1'b1, hs: 1'b0, sub: 1'b0, vs: 1'b0, lv: 1'b0, pix: 18'd0};

    logic [17:0] wline[$];
    logic [17:0] stored[$];
    int   m_L, m_n, m_edges;
    bit   m_last_hs, m_vs, m_vs1;
    ent_t hold1, hold2, cur_exp;

    task automatic model_reset();
        wline.delete();
        stored.delete();
        m_L = 0; m_n = 0;
        m_last_hs = 0; m_vs = 0; m_vs1 = 0;
        hold1 = RST_ENT; hold2 = RST_ENT; cur_exp = RST_ENT;
    endtask

    task automatic model_edge(input bit ce, input bit hs, input bit vs, input logic [17:0] px);
        bit   hedge;
        int   p;
        ent_t e;
        hedge = ce && hs && !m_last_hs;
        if (ce) begin
            if (wline.size() < MAX_W) wline.push_back(px);
            else                      wline[MAX_W-1] = px;
            if (hedge) begin
                stored  = wline;
                m_L     = wline.size();
                wline.delete();
                m_edges++;
            end
            m_last_hs = hs;
            m_vs      = vs;
        end
        if (hedge) m_n = 0;
        else if (m_n < (1 << 24)) m_n++;
        // first pass, second pass, then hold on the last pixel
        if (m_L == 0)          p = 0;
        else if (m_n < m_L)    p = m_n;
        else if (m_n < 2*m_L)  p = m_n - m_L;
        else                   p = m_L - 1;
        if (p == 0) m_vs1 = m_vs;
        e.blank = (m_L == 0);
        e.lv    = (m_L != 0);
        e.sub   = (m_L != 0) && (m_n >= m_L);
        e.hs    = (p < HSW);
        e.vs    = m_vs1;
        e.pix   = (m_L != 0) ? stored[p] : 18'd0;
        // outputs trail the read position by two pclk
        cur_exp = hold2;
        hold2   = hold1;
        hold1   = e;
    endtask

    // ---------------- monitors ----------------
    int cyc = 0, last_rise = -1, min_space = 0, hs_run = 0, last_run = 0;
    int cnt31 = 0, vs_lines = 0;
    bit prev_hs = 0;
    bit rst_drv;

    task automatic step(input bit ce, input bit hs, input bit vs, input logic [17:0] px);
        logic [5:0] er, eg, eb;
        @(negedge pclk);
        reset = rst_drv; ce_pix = ce; hs_in = hs; vs_in = vs;
        {r_in, g_in, b_in} = px;
        @(posedge pclk);
        if (rst_drv) model_reset();
        else         model_edge(ce, hs, vs, px);
        #1;
        cyc++;
        {er, eg, eb} = cur_exp.blank ? 18'd0 : cur_exp.pix;
        if (SL && scanlines && cur_exp.sub) begin
            er = er >> 1; eg = eg >> 1; eb = eb >> 1;
        end
        chk("cyc_rgb", int'({r_out, g_out, b_out}), int'({er, eg, eb}));
        chk("cyc_hs", int'(hs_out), int'(cur_exp.hs && !cur_exp.blank));
        if (cur_exp.lv) chk("cyc_vs", int'(vs_out), int'(cur_exp.vs));
        if (hs_out && !prev_hs) begin
            if (last_rise >= 0 && cyc - last_rise < min_space) min_space = cyc - last_rise;
            last_rise = cyc;
            if (vs_out) vs_lines++;
        end
        if (hs_out) hs_run++;
        else begin
            if (prev_hs) last_run = hs_run;
            hs_run = 0;
        end
        if ({r_out, g_out, b_out} == {6'd31, 6'd31, 6'd31}) cnt31++;
        prev_hs = hs_out;
    endtask

    // ---------------- stimulus generator ----------------
    function automatic int hs_start(input int npix);
        return (npix >= 640) ? 336 : npix / 2;
    endfunction

    function automatic int hs_len(input int npix);
        return (npix >= 640) ? 32 : npix / 4;
    endfunction

    // pattern 0: ramp indexed by buffer position, 1: random, 2: constant 63
    function automatic logic [17:0] pix_data(input int pat, input int i, input int npix, input int hs0);
        logic [5:0] x;
        x = 6'((i - hs0 - 1 + npix) % npix);
        case (pat)
            0:       return {x, ~x, 6'(i)};
            1:       return 18'($urandom);
            default: return {6'd63, 6'd63, 6'd63};
        endcase
    endfunction

    task automatic run_pixel(input int npix, input int i, input int hs0, input int mode, input int pat, input bit vs);
        int idles;
        bit hs;
        hs = (i >= hs0) && (i < hs0 + hs_len(npix));
        step(1'b1, hs, vs, pix_data(pat, i, npix, hs0));
        idles = (mode == 0) ? 1 : (mode == 1) ? int'($urandom_range(1, 3)) : 0;
        for (int k = 0; k < idles; k++)
            step(1'b0, 1'($urandom), 1'($urandom), 18'($urandom));
    endtask

    task automatic run_line(input int npix, input int hs0, input int mode, input int pat, input bit vs);
        for (int i = 0; i < npix; i++) run_pixel(npix, i, hs0, mode, pat, vs);
    endtask

    typedef struct {
        int npix;
        int mode;      // 0: ce every 2nd pclk, 1: random gaps, 2: ce every pclk
        int pat;
        bit scan;
        int exp_len;   // expected output sub-line length in pclk
    } vec_t;

    vec_t vecs[7];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: actual timeout, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit reached;
        int e0;

        vecs[0] = '{640,  0, 0, 1'b0, 640};
        vecs[1] = '{640,  0, 1, 1'b0, 640};
        vecs[2] = '{1100, 0, 1, 1'b0, 1024};
        vecs[3] = '{100,  1, 1, 1'b0, 100};
        vecs[4] = '{64,   2, 1, 1'b0, 64};
        vecs[5] = '{200,  0, 2, 1'b1, 200};
        vecs[6] = '{200,  0, 2, 1'b0, 200};

        reset = 1'b1; ce_pix = 0; hs_in = 0; vs_in = 0; scanlines = 0;
        r_in = 0; g_in = 0; b_in = 0;
        m_edges = 0;
        rst_drv = 1'b1;
        model_reset();
        repeat (3) step(1'b0, 1'b0, 1'b0, 18'd0);
        chk("rst_rgb", int'({r_out, g_out, b_out}), 0);
        chk("rst_hs", int'(hs_out), 0);
        chk("rst_vs", int'(vs_out), 0);
        rst_drv = 1'b0;

        // startup: data but no hs edge yet
        for (int i = 0; i < 300; i++) run_pixel(640, i, 9999, 0, 1, 1'b0);
        chk("startup_rgb", int'({r_out, g_out, b_out}), 0);
        chk("startup_hs", int'(hs_out), 0);

        foreach (vecs[v]) begin
            scanlines = vecs[v].scan;
            repeat (2) run_line(vecs[v].npix, hs_start(vecs[v].npix), vecs[v].mode, vecs[v].pat, 1'b0);
            min_space = 1 << 30; cnt31 = 0; last_run = 0;
            repeat (2) run_line(vecs[v].npix, hs_start(vecs[v].npix), vecs[v].mode, vecs[v].pat, 1'b0);
            chk($sformatf("line_len_row%0d", v), min_space, vecs[v].exp_len);
            chk($sformatf("hs_width_row%0d", v), last_run, HSW);
            if (vecs[v].pat == 2)
                chk($sformatf("scan_half_row%0d", v), int'(cnt31 > 0), int'(SL && vecs[v].scan));
        end
        scanlines = 0;

        // async reset with the read position around 200
        repeat (2) run_line(640, 336, 0, 0, 1'b0);
        e0 = m_edges;
        reached = 0;
        for (int i = 0; i < 640 && !reached; i++) begin
            run_pixel(640, i, 336, 0, 0, 1'b0);
            reached = (m_edges > e0) && (m_n >= 200);
        end
        chk("reach_rd200", int'(reached), 1);
        chk("pre_arst_rgb_nonzero", int'({r_out, g_out, b_out} != 18'd0), 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_rgb", int'({r_out, g_out, b_out}), 0);
        chk("arst_hs", int'(hs_out), 0);
        chk("arst_vs", int'(vs_out), 0);
        model_reset();
        rst_drv = 1'b1;
        repeat (2) step(1'b0, 1'b0, 1'b0, 18'd0);
        rst_drv = 1'b0;
        repeat (2) run_line(640, 336, 0, 0, 1'b0);
        min_space = 1 << 30;
        repeat (2) run_line(640, 336, 0, 0, 1'b0);
        chk("recover_len", min_space, 640);

        // vsync across four input lines -> eight output lines
        vs_lines = 0;
        for (int l = 0; l < 10; l++) run_line(100, 10, 0, 1, (l >= 3) && (l <= 6));
        chk("vs_lines", vs_lines, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
